// File: rtl/wb_arbiter_rr.sv
// N-master to 1-slave Wishbone B3 arbiter, round-robin or fixed priority, registered one-hot grant.
// Grant lands 1 cycle after a request and is held for the owner's whole cyc; one dead cycle follows each release.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 0
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [AW-1:0]             wbs_adr_o,
  output logic [DW-1:0]             wbs_dat_o,
  output logic [DW/8-1:0]           wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [DW-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int SW = DW / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [IW-1:0]          win_idx;
  logic [IW-1:0]          cand_idx;
  logic                   win_found;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   timeout_hit;
  int                     cand;

  // Winner selection; round-robin scans from last+1, wrapping at most once.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (wbm_cyc_i[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        cand = int'(last_q) + 1 + k;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
        cand_idx = IW'(cand);
        if (!win_found && wbm_cyc_i[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  assign own_cyc = |(wbm_cyc_i & grant_q);
  assign own_stb = |(wbm_stb_i & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = NUM_MASTERS'(1) << win_idx;
          if (ARB_MODE == 0) last_d = win_idx;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // AND-OR mux on the one-hot grant: an empty grant (IDLE/reset) yields all zeros.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        wbs_adr_o = wbm_adr_i[i*AW +: AW];
        wbs_dat_o = wbm_dat_i[i*DW +: DW];
        wbs_sel_o = wbm_sel_i[i*SW +: SW];
        wbs_we_o  = wbm_we_i[i];
        wbs_cti_o = wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbm_bte_i[i*2 +: 2];
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] wd_cnt;
      logic          resp;

      assign resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
      // A real response in the same cycle beats the forced err.
      assign timeout_hit = (state_q == BUSY) && own_stb && !resp &&
                           (wd_cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
          wd_cnt <= '0;
        end else if ((state_q != BUSY) || resp || timeout_hit) begin
          wd_cnt <= '0;
        end else if (own_stb) begin
          wd_cnt <= wd_cnt + CW'(1);
        end
      end
    end else begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign wbs_cyc_o = own_cyc;
  assign wbs_stb_o = own_stb & ~timeout_hit;
  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
  assign wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i | timeout_hit}};
  assign wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i}};
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench: round-robin DUT with TIMEOUT=8 and a fixed-priority DUT share one set of master/slave stimulus.
module tb_wb_arbiter_rr;

  logic        clk;
  logic        rst_n;
  logic [95:0] m_adr;
  logic [95:0] m_dat;
  logic [11:0] m_sel;
  logic [2:0]  m_we, m_cyc, m_stb;
  logic [8:0]  m_cti;
  logic [5:0]  m_bte;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;

  logic [95:0] rr_mdat, fp_mdat;
  logic [2:0]  rr_ack, rr_err, rr_rty, fp_ack, fp_err, fp_rty;
  logic [31:0] rr_adr, rr_dat, fp_adr, fp_dat;
  logic [3:0]  rr_sel, fp_sel;
  logic        rr_we, rr_cyc, rr_stb, fp_we, fp_cyc, fp_stb;
  logic [2:0]  rr_cti, fp_cti;
  logic [1:0]  rr_bte, fp_bte;
  logic [2:0]  rr_grant, fp_grant;

  int errors = 0;
  int checks = 0;

  wb_arbiter_rr #(.NUM_MASTERS(3), .AW(32), .DW(32), .ARB_MODE(0), .TIMEOUT(8)) u_rr (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(rr_mdat), .wbm_ack_o(rr_ack), .wbm_err_o(rr_err), .wbm_rty_o(rr_rty),
    .wbs_adr_o(rr_adr), .wbs_dat_o(rr_dat), .wbs_sel_o(rr_sel), .wbs_we_o(rr_we),
    .wbs_cyc_o(rr_cyc), .wbs_stb_o(rr_stb), .wbs_cti_o(rr_cti), .wbs_bte_o(rr_bte),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(rr_grant)
  );

  wb_arbiter_rr #(.NUM_MASTERS(3), .AW(32), .DW(32), .ARB_MODE(1), .TIMEOUT(0)) u_fp (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(fp_mdat), .wbm_ack_o(fp_ack), .wbm_err_o(fp_err), .wbm_rty_o(fp_rty),
    .wbs_adr_o(fp_adr), .wbs_dat_o(fp_dat), .wbs_sel_o(fp_sel), .wbs_we_o(fp_we),
    .wbs_cyc_o(fp_cyc), .wbs_stb_o(fp_stb), .wbs_cti_o(fp_cti), .wbs_bte_o(fp_bte),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(fp_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    m_cyc = 3'b111;
    m_stb = 3'b111;
    s_ack = 1'b1;
    step();
    step();
    checks++; if (rr_grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", rr_grant); end
    checks++; if (rr_cyc !== 1'b0 || rr_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b want 00", rr_cyc, rr_stb); end
    checks++; if (rr_ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b want 000", rr_ack); end
    checks++; if (fp_grant !== 3'b000 || rr_adr !== 32'h0) begin errors++; $display("FAIL reset_fp_adr: grant %b adr %h want 000/0", fp_grant, rr_adr); end
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rr_rotation;
    logic [2:0]  exp_g [4];
    logic [31:0] exp_a [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h1000_0000};
    m_cyc = 3'b111;
    m_stb = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (rr_grant !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, rr_grant, exp_g[k]); end
      checks++; if (rr_cyc !== 1'b1 || rr_adr !== exp_a[k]) begin errors++; $display("FAIL rr_mux[%0d]: cyc %b adr %h want 1/%h", k, rr_cyc, rr_adr, exp_a[k]); end
      s_ack = 1'b1;
      #1;
      checks++; if (rr_ack !== exp_g[k]) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", k, rr_ack, exp_g[k]); end
      checks++; if (rr_mdat !== {3{s_dat}}) begin errors++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, rr_mdat, {3{s_dat}}); end
      step();
      s_ack = 1'b0;
      m_cyc = m_cyc & ~exp_g[k];
      m_stb = m_stb & ~exp_g[k];
      #1;
      checks++; if (rr_cyc !== 1'b0 || rr_grant !== exp_g[k]) begin errors++; $display("FAIL rr_release[%0d]: cyc %b grant %b want 0/%b", k, rr_cyc, rr_grant, exp_g[k]); end
      step();
      checks++; if (rr_grant !== 3'b000) begin errors++; $display("FAIL rr_dead[%0d]: got %b want 000", k, rr_grant); end
      m_cyc = m_cyc | exp_g[k];
      m_stb = m_stb | exp_g[k];
    end
    idle_all();
  endtask

  task automatic test_fixed_prio;
    m_cyc = 3'b110;
    m_stb = 3'b110;
    step();
    checks++; if (fp_grant !== 3'b010) begin errors++; $display("FAIL fp_first: got %b want 010", fp_grant); end
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    step();
    checks++; if (fp_grant !== 3'b010) begin errors++; $display("FAIL fp_no_preempt: got %b want 010", fp_grant); end
    s_ack = 1'b1;
    #1;
    checks++; if (fp_ack !== 3'b010) begin errors++; $display("FAIL fp_ack: got %b want 010", fp_ack); end
    step();
    s_ack = 1'b0;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    step();
    checks++; if (fp_grant !== 3'b000) begin errors++; $display("FAIL fp_dead: got %b want 000", fp_grant); end
    step();
    checks++; if (fp_grant !== 3'b001 || fp_adr !== 32'h1000_0000) begin errors++; $display("FAIL fp_second: grant %b adr %h want 001/10000000", fp_grant, fp_adr); end
    idle_all();
  endtask

  task automatic test_burst;
    logic [2:0]  exp_cti;
    logic [31:0] exp_adr;
    m_cyc = 3'b001;
    m_stb = 3'b001;
    m_cti[2:0] = 3'b010;
    m_bte[1:0] = 2'b00;
    step();
    checks++; if (rr_grant !== 3'b001) begin errors++; $display("FAIL burst_grant: got %b want 001", rr_grant); end
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_cti = (b == 3) ? 3'b111 : 3'b010;
      exp_adr = 32'h1000_0000 + 32'(4 * b);
      m_cti[2:0]  = exp_cti;
      m_adr[31:0] = exp_adr;
      s_ack = 1'b1;
      #1;
      checks++; if (rr_grant !== 3'b001 || rr_ack !== 3'b001) begin errors++; $display("FAIL burst_beat[%0d]: grant %b ack %b want 001/001", b, rr_grant, rr_ack); end
      checks++; if (rr_cti !== exp_cti || rr_adr !== exp_adr) begin errors++; $display("FAIL burst_addr[%0d]: cti %b adr %h want %b/%h", b, rr_cti, rr_adr, exp_cti, exp_adr); end
      step();
    end
    s_ack = 1'b0;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    m_cti[2:0] = 3'b000;
    m_adr[31:0] = 32'h1000_0000;
    step();
    checks++; if (rr_grant !== 3'b000) begin errors++; $display("FAIL burst_dead: got %b want 000", rr_grant); end
    step();
    checks++; if (rr_grant !== 3'b010 || rr_cyc !== 1'b1 || rr_adr !== 32'h2000_0000) begin errors++; $display("FAIL burst_next: grant %b cyc %b adr %h want 010/1/20000000", rr_grant, rr_cyc, rr_adr); end
    idle_all();
  endtask

  task automatic test_watchdog;
    m_cyc = 3'b100;
    m_stb = 3'b100;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        checks++; if (rr_err !== 3'b000 || rr_stb !== 1'b1) begin errors++; $display("FAIL wd_wait[%0d]: err %b stb %b want 000/1", i, rr_err, rr_stb); end
      end else begin
        checks++; if (rr_err !== 3'b100 || rr_stb !== 1'b0) begin errors++; $display("FAIL wd_hit: err %b stb %b want 100/0", rr_err, rr_stb); end
      end
      step();
    end
    checks++; if (rr_err !== 3'b000 || rr_stb !== 1'b1 || fp_err !== 3'b000) begin errors++; $display("FAIL wd_after: err %b stb %b fp_err %b want 000/1/000", rr_err, rr_stb, fp_err); end
    idle_all();
  endtask

  task automatic test_ack_vs_timeout;
    m_cyc = 3'b100;
    m_stb = 3'b100;
    step();
    repeat (7) step();
    s_ack = 1'b1;
    #1;
    checks++; if (rr_ack !== 3'b100 || rr_err !== 3'b000 || rr_stb !== 1'b1) begin errors++; $display("FAIL ack_wins: ack %b err %b stb %b want 100/000/1", rr_ack, rr_err, rr_stb); end
    step();
    s_ack = 1'b0;
    #1;
    checks++; if (rr_err !== 3'b000) begin errors++; $display("FAIL ack_clears: err %b want 000", rr_err); end
    idle_all();
  endtask

  task automatic test_reset_mid;
    m_cyc = 3'b010;
    m_stb = 3'b010;
    step();
    checks++; if (rr_grant !== 3'b010) begin errors++; $display("FAIL rst_pre: got %b want 010", rr_grant); end
    s_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rr_cyc !== 1'b0 || rr_grant !== 3'b000 || rr_ack !== 3'b000) begin errors++; $display("FAIL rst_async: cyc %b grant %b ack %b want 0/000/000", rr_cyc, rr_grant, rr_ack); end
    #1;
    rst_n = 1'b1;
    s_ack = 1'b0;
    m_cyc = 3'b111;
    m_stb = 3'b111;
    step();
    checks++; if (rr_grant !== 3'b001 || rr_cyc !== 1'b1) begin errors++; $display("FAIL rst_regrant: grant %b cyc %b want 001/1", rr_grant, rr_cyc); end
    idle_all();
  endtask

  initial begin
    rst_n = 1'b0;
    m_adr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    m_dat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    m_sel = 12'hFFF;
    m_we  = 3'b000;
    m_cyc = '0;
    m_stb = '0;
    m_cti = '0;
    m_bte = '0;
    s_dat = 32'hCAFE_F00D;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    test_reset();
    test_rr_rotation();
    test_fixed_prio();
    test_burst();
    test_watchdog();
    test_ack_vs_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
